// File: rtl/clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_ctrl
// Description : Programmable integer clock divider with run/drain/stop
//               control, handshaked divisor updates applied only at period
//               boundaries, and a sticky error flag for illegal divisors.
//               Optional feature macro: CLKDIV_PCNT_EN adds a 16-bit
//               period counter output (period_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_ctrl #(
  parameter int W       = 8,
  parameter int DEF_DIV = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         div_req,
  input  logic [W-1:0] div_val,
  input  logic         err_clr,
  output logic         clk_div,
  output logic         tick,
  output logic         div_ack,
  output logic         busy,
  output logic         err,
  output logic [W-1:0] cur_div
`ifdef CLKDIV_PCNT_EN
  ,
  output logic [15:0]  period_cnt
`endif
);

  // STOP: idle, output low. RUN: counting periods. DRAIN: en has dropped,
  // the current period is being completed before stopping.
  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [W-1:0] RST_DIV = W'(DEF_DIV);
  localparam logic [W-1:0] MIN_DIV = W'(2);

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nx;
  logic [W-1:0] cur_div_nx;
  logic [W-1:0] pend_div;
  logic [W-1:0] pend_div_nx;
  logic         clk_div_nx;
  logic         tick_nx;
  logic         div_ack_nx;
  logic         busy_nx;
  logic         err_nx;

  logic         accept;
  logic         illegal;
  logic         at_wrap;
  logic [W:0]   high_len;

  // A request is taken only when nothing is pending and the previous ack
  // has retired; the ack cycle itself is excluded so a held request is
  // never accepted twice.
  assign accept  = div_req & ~busy & ~div_ack;
  assign illegal = (div_val < MIN_DIV);
  assign at_wrap = (cnt == (cur_div - 1'b1));

  // Next-state, counter, divisor handoff and output decode
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    cur_div_nx  = cur_div;
    pend_div_nx = pend_div;
    busy_nx     = busy;
    err_nx      = err & ~err_clr;
    div_ack_nx  = 1'b0;
    tick_nx     = 1'b0;
    clk_div_nx  = 1'b0;
    high_len    = '0;

    unique case (state)
      STOP: begin
        // No period is in flight, so a pending divisor lands immediately.
        if (busy) begin
          cur_div_nx = pend_div;
          busy_nx    = 1'b0;
        end
        if (en) begin
          state_nx = RUN;
          cnt_nx   = '0;
          tick_nx  = 1'b1;
        end
      end

      RUN, DRAIN: begin
        if (at_wrap) begin
          // Period boundary: the only point where the divisor may change
          // or where the divider may stop.
          cnt_nx = '0;
          if (busy) begin
            cur_div_nx = pend_div;
            busy_nx    = 1'b0;
          end
          if (en) begin
            state_nx = RUN;
            tick_nx  = 1'b1;
          end else begin
            state_nx = STOP;
          end
        end else begin
          // Mid-period: keep counting; en only selects RUN vs DRAIN so a
          // re-enable during DRAIN continues the same period seamlessly.
          cnt_nx   = cnt + 1'b1;
          state_nx = en ? RUN : DRAIN;
        end
      end

      default: begin
        state_nx = STOP;
        cnt_nx   = '0;
      end
    endcase

    // Accept can only occur with busy low, so it never collides with the
    // pending-divisor handoff above.
    if (accept) begin
      div_ack_nx = 1'b1;
      if (illegal) begin
        err_nx = 1'b1;
      end else begin
        pend_div_nx = div_val;
        busy_nx     = 1'b1;
      end
    end

    // High phase is ceil(N/2) cycles, evaluated with the divisor that
    // governs the cycle being produced.
    high_len = ({1'b0, cur_div_nx} + {{W{1'b0}}, 1'b1}) >> 1;
    if (state_nx != STOP) begin
      clk_div_nx = ({1'b0, cnt_nx} < high_len);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STOP;
      cnt      <= '0;
      cur_div  <= RST_DIV;
      pend_div <= '0;
      clk_div  <= 1'b0;
      tick     <= 1'b0;
      div_ack  <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cur_div  <= cur_div_nx;
      pend_div <= pend_div_nx;
      clk_div  <= clk_div_nx;
      tick     <= tick_nx;
      div_ack  <= div_ack_nx;
      busy     <= busy_nx;
      err      <= err_nx;
    end
  end

`ifdef CLKDIV_PCNT_EN
  // Count divided-clock periods; wraps naturally from 16'hFFFF to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clkdiv_ctrl
// Description : Self-checking bench for clkdiv_ctrl: a reset check, a vector
//               table, hand-written multi-cycle sequences and a randomized
//               run against a behavioural period model. Honours
//               CLKDIV_PCNT_EN when the optional counter is built.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkdiv_ctrl;

  localparam int W   = 8;
  localparam int DEF = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic         div_req;
  logic [W-1:0] div_val;
  logic         err_clr;
  logic         clk_div;
  logic         tick;
  logic         div_ack;
  logic         busy;
  logic         err;
  logic [W-1:0] cur_div;
`ifdef CLKDIV_PCNT_EN
  logic [15:0]  period_cnt;
`endif

  clkdiv_ctrl #(.W(W), .DEF_DIV(DEF)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_req (div_req),
    .div_val (div_val),
    .err_clr (err_clr),
    .clk_div (clk_div),
    .tick    (tick),
    .div_ack (div_ack),
    .busy    (busy),
    .err     (err),
    .cur_div (cur_div)
`ifdef CLKDIV_PCNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Output bundle: {clk_div, tick, div_ack, busy, err, cur_div}
  function automatic logic [12:0] expv(bit c, bit t, bit a, bit b, bit e, int cur);
    return {c, t, a, b, e, 8'(cur)};
  endfunction

  function automatic logic [12:0] dut_out();
    return {clk_div, tick, div_ack, busy, err, cur_div};
  endfunction

  task automatic check(string nm, logic [12:0] act, logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got clk/tick/ack/busy/err=%b cur=%0d, want %b cur=%0d",
               nm, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; div_req = 1'b0; div_val = '0; err_clr = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  // A period is tracked as "position within the current period" plus an
  // on/off flag; draining is implicit (stop decision taken at the boundary).
  int m_n, m_pend, m_pos;
  bit m_on, m_tick, m_ack, m_err, m_clk;

  function automatic void model_reset();
    m_n = DEF; m_pend = -1; m_pos = 0;
    m_on = 0; m_tick = 0; m_ack = 0; m_err = 0; m_clk = 0;
  endfunction

  function automatic void model_step(bit en_i, bit req_i, int val_i, bit clr_i);
    bit acc;
    acc = req_i && (m_pend < 0) && !m_ack;
    if (!m_on) begin
      if (m_pend >= 0) begin m_n = m_pend; m_pend = -1; end
      m_on = en_i; m_pos = 0; m_tick = en_i;
    end else if (m_pos == m_n - 1) begin
      if (m_pend >= 0) begin m_n = m_pend; m_pend = -1; end
      m_pos = 0; m_on = en_i; m_tick = en_i;
    end else begin
      m_pos++; m_tick = 0;
    end
    m_err = (m_err && !clr_i) || (acc && val_i < 2);
    m_ack = acc;
    if (acc && val_i >= 2) m_pend = val_i;
    m_clk = m_on && (m_pos < (m_n + 1) / 2);
  endfunction

  function automatic logic [12:0] model_out();
    return expv(m_clk, m_tick, m_ack, (m_pend >= 0), m_err, m_n);
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       en; logic req; logic [7:0] val; logic clr;
    logic       c; logic t; logic a; logic b; logic e; logic [7:0] cur;
  } vec_t;

  function automatic vec_t mkv(bit en_i, bit rq, int v, bit cl,
                               bit c, bit t, bit a, bit b, bit e, int cur);
    vec_t r;
    r.en = en_i; r.req = rq; r.val = 8'(v); r.clr = cl;
    r.c = c; r.t = t; r.a = a; r.b = b; r.e = e; r.cur = 8'(cur);
    return r;
  endfunction

  vec_t tv [16];

  initial begin
    // STOP update to 5, run with 3 high / 2 low, illegal request,
    // err_clr, drain to stop, and err_clr coinciding with an illegal request.
    tv[0]  = mkv(0,1,5,0, 0,0,1,1,0,8);
    tv[1]  = mkv(0,0,0,0, 0,0,0,0,0,5);
    tv[2]  = mkv(1,0,0,0, 1,1,0,0,0,5);
    tv[3]  = mkv(1,0,0,0, 1,0,0,0,0,5);
    tv[4]  = mkv(1,0,0,0, 1,0,0,0,0,5);
    tv[5]  = mkv(1,0,0,0, 0,0,0,0,0,5);
    tv[6]  = mkv(1,0,0,0, 0,0,0,0,0,5);
    tv[7]  = mkv(1,0,0,0, 1,1,0,0,0,5);
    tv[8]  = mkv(1,1,1,0, 1,0,1,0,1,5);
    tv[9]  = mkv(1,0,0,0, 1,0,0,0,1,5);
    tv[10] = mkv(1,0,0,1, 0,0,0,0,0,5);
    tv[11] = mkv(0,0,0,0, 0,0,0,0,0,5);
    tv[12] = mkv(0,0,0,0, 0,0,0,0,0,5);
    tv[13] = mkv(0,0,0,0, 0,0,0,0,0,5);
    tv[14] = mkv(0,1,0,1, 0,0,1,0,1,5);
    tv[15] = mkv(0,0,0,0, 0,0,0,0,1,5);

    // ---- reset state ----
    en = 1'b0; div_req = 1'b0; div_val = '0; err_clr = 1'b0;
    rst = 1'b1;
    step();
    check("reset", dut_out(), expv(0,0,0,0,0,DEF));
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < 16; i++) begin
      en = tv[i].en; div_req = tv[i].req; div_val = tv[i].val; err_clr = tv[i].clr;
      step();
      check($sformatf("vec%0d", i), dut_out(),
            {tv[i].c, tv[i].t, tv[i].a, tv[i].b, tv[i].e, tv[i].cur});
    end

    // ---- default divisor 8: 4 high / 4 low, first tick one cycle after en ----
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      check("div8", dut_out(), expv((k % 8) < 4, (k % 8) == 0, 0, 0, 0, 8));
    end

    // ---- change 8 -> 3 requested at cnt=2, applied at the wrap ----
    step(); step(); step();
    div_req = 1'b1; div_val = 8'd3;
    for (int j = 0; j < 14; j++) begin
      int c;
      step();
      if (j < 5) begin
        c = 3 + j;
        check("n8to3_old", dut_out(), expv(c < 4, 0, j == 0, 1, 0, 8));
      end else begin
        c = (j - 5) % 3;
        check("n8to3_new", dut_out(), expv(c < 2, c == 0, 0, 0, 0, 3));
      end
      if (j == 0) div_req = 1'b0;
    end

    // ---- N=6, en dropped at cnt=1: period completes then STOP ----
    do_reset();
    div_req = 1'b1; div_val = 8'd6;
    step();
    check("n6_ack", dut_out(), expv(0,0,1,1,0,8));
    div_req = 1'b0;
    step();
    check("n6_apply", dut_out(), expv(0,0,0,0,0,6));
    en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("n6_run", dut_out(), expv(c < 3, c == 0, 0, 0, 0, 6));
    end
    en = 1'b0;
    for (int c = 2; c < 6; c++) begin
      step();
      check("n6_drain", dut_out(), expv(c < 3, 0, 0, 0, 0, 6));
    end
    for (int i = 0; i < 6; i++) begin
      step();
      check("n6_stop", dut_out(), expv(0,0,0,0,0,6));
    end

    // ---- async reset mid-period with busy and err set ----
    do_reset();
    div_req = 1'b1; div_val = 8'd1;
    step();
    check("rst_pre_err", dut_out(), expv(0,0,1,0,1,8));
    div_req = 1'b0; en = 1'b1;
    step();
    check("rst_pre_run", dut_out(), expv(1,1,0,0,1,8));
    div_req = 1'b1; div_val = 8'd4;
    step();
    check("rst_pre_ack", dut_out(), expv(1,0,1,1,1,8));
    div_req = 1'b0;
    step();
    check("rst_pre_busy", dut_out(), expv(1,0,0,1,1,8));
    rst = 1'b1;
    #2;
    check("rst_mid", dut_out(), expv(0,0,0,0,0,DEF));
`ifdef CLKDIV_PCNT_EN
    total++;
    if (period_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rst_pcnt: got %0d want 0", period_cnt);
    end
`endif
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      check("rst_resume", dut_out(), expv((k % 8) < 4, (k % 8) == 0, 0, 0, 0, DEF));
    end

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      if ($urandom_range(15) == 0) en = ~en;
      if (!div_req && $urandom_range(9) == 0) begin
        div_req = 1'b1;
        r = int'($urandom_range(9));
        if (r == 0)      div_val = 8'($urandom_range(1));
        else if (r == 1) div_val = 8'($urandom_range(40, 2));
        else             div_val = 8'($urandom_range(12, 2));
      end
      err_clr = ($urandom_range(7) == 0);
      model_step(en, div_req, int'(div_val), err_clr);
      step();
      check("rand", dut_out(), model_out());
      if (m_ack) div_req = 1'b0;
      if ($urandom_range(599) == 0) begin
        rst = 1'b1;
        #2;
        model_reset();
        check("rand_rst", dut_out(), model_out());
        rst = 1'b0;
        div_req = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter W, default 8: divisor width in bits.
REQ-003 Parameter DEF_DIV, default 8: divisor loaded at reset; legal range 2..2^W-1.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 en  input  1  run enable; level-sensitive.
REQ-007 div_req  input  1  divisor update request; held until div_ack.
REQ-008 div_val  input  W  requested divisor N; sampled with div_req.
REQ-009 err_clr  input  1  clears err.
REQ-010 clk_div  output  1  registered divided clock.
REQ-011 tick  output  1  one-cycle pulse coincident with each clk_div rising edge.
REQ-012 div_ack  output  1  one-cycle acceptance/rejection pulse.
REQ-013 busy  output  1  accepted divisor pending, not yet applied.
REQ-014 err  output  1  sticky; illegal divisor was rejected.
REQ-015 cur_div  output  W  divisor currently in effect.

Function
REQ-016 FSM states SHALL be STOP, RUN and DRAIN.
REQ-017 The period counter cnt SHALL run 0..N-1, wrapping to 0; period is N clk cycles.
REQ-018 clk_div SHALL be high for cnt in 0..H-1 and low otherwise, with H = ceil(N/2); even N gives 50% duty, odd N has one extra high cycle.
REQ-019 In STOP with en=1, the next cycle SHALL enter RUN with cnt=0, clk_div=1 and tick=1.
REQ-020 In RUN with en=0, the block SHALL enter DRAIN, finish the current period, then go to STOP at the wrap with clk_div=0.
REQ-021 In DRAIN with en=1, the block SHALL return to RUN with no glitch or period truncation.
REQ-022 A request SHALL be accepted when div_req=1, busy=0 and div_ack=0; div_ack pulses on the next cycle.
REQ-023 An accepted div_val of 0 or 1 SHALL set err, SHALL be acknowledged, and SHALL NOT change busy or cur_div.
REQ-024 An accepted legal div_val SHALL be stored as pending and SHALL set busy on the div_ack cycle.
REQ-025 In RUN or DRAIN, a pending divisor SHALL apply at the period wrap only; the new period starts with the new N, and busy clears on that cycle.
REQ-026 In STOP, a pending divisor SHALL apply on the cycle after acceptance.
REQ-027 While busy=1, div_req SHALL be ignored and no div_ack SHALL be generated.
REQ-028 When err_clr and a new illegal request coincide, err SHALL remain set.
REQ-029 tick SHALL never assert in STOP.

Reset
REQ-030 On rst, the block SHALL immediately force state=STOP, cnt=0, cur_div=DEF_DIV, pending cleared, and clk_div, tick, div_ack, busy and err all 0.
REQ-031 Reset mid-period SHALL abort the period and drop any pending divisor; operation resumes only through STOP→RUN.

Configuration
REQ-032 With macro CLKDIV_PCNT_EN defined, the block SHALL add output period_cnt [15:0], which increments on each tick, wraps at 0xFFFF, and resets to 0.
REQ-033 Without CLKDIV_PCNT_EN, period_cnt SHALL be absent and there SHALL be no counter logic.

Verification
REQ-034 Reset, en=1, DEF_DIV=8 → clk_div 4 high / 4 low, tick every 8 cycles, first tick one cycle after en.
REQ-035 N=5 applied in STOP, then en=1 → clk_div 3 high / 2 low, period 5.
REQ-036 While running N=8, request N=3 at cnt=2 → div_ack the next cycle, busy until wrap, then 2 high / 1 low, with no short or long period.
REQ-037 Request div_val=1 → div_ack pulse, err=1, cur_div unchanged; err_clr → err=0.
REQ-038 en dropped at cnt=1 with N=6 → clk_div completes the period, then STOP with clk_div=0 and no further tick.
REQ-039 rst asserted mid-period with busy=1 → all outputs 0, cur_div=DEF_DIV; with CLKDIV_PCNT_EN, period_cnt=0.
